stream_match: RTL and testbench

STREAM_MATCH -- requirements
Module: stream_match

---
 rtl/stream_match.sv | 139 +++++++++++++
 tb/tb_stream_match.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_match.sv
// stream_match
// Collects a serial bit stream (MSB first) into a WIDTH-bit shift register.
// When end_of_sequence closes the stream, the captured value goes out on
// data_out. The next cycle compares it against NUM_KEYS prestored keys and
// pulses done with the match result.
//
// Ports
//   clk              single clock, rising edge
//   rst_n            asynchronous active-low reset
//   bit_valid        bit_in carries a stream bit this cycle
//   bit_in           serial data bit, MSB of the sequence first
//   end_of_sequence  one-cycle strobe that closes the current sequence
//   bit_ready        high while bits and end_of_sequence are accepted
//   data_out         last captured sequence, right-aligned, zero-extended
//   done             one-cycle pulse when the result outputs update
//   match            captured sequence equals a key and has exactly WIDTH bits
//   match_idx        lowest matching key index, 0 when match=0
//   len_err          captured length was not exactly WIDTH bits
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | shifting in bits; end_of_sequence captures data_out
// COMPARE | compare data_out with all keys, register result, pulse done
module stream_match #(
    parameter int WIDTH    = 128,
    parameter int NUM_KEYS = 4,
    parameter logic [WIDTH*NUM_KEYS-1:0] KEYS = {
        128'hFFEEDDCCBBAA99887766554433221100,
        128'h0123456789ABCDEFFEDCBA9876543210,
        128'hDEADBEEFCAFEF00D0BADC0DE12345678,
        128'h0
    },
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             end_of_sequence,
    output logic             bit_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             match,
    output logic [IDX_W-1:0] match_idx,
    output logic             len_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        COMPARE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   shift_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               ovf_nxt;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               len_bad;

    assign bit_ready = (state == COLLECT);

    // A same-cycle bit is applied before end_of_sequence captures, so the
    // capture path and the normal shift path share this next-state value.
    always_comb begin
        shift_nxt = shift_q;
        count_nxt = count_q;
        ovf_nxt   = ovf_q;
        if (bit_valid) begin
            if (count_q < FULL_CNT) begin
                shift_nxt = {shift_q[WIDTH-2:0], bit_in};
                count_nxt = count_q + CNT_W'(1);
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    // Scan from the top index down so the lowest matching key wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (data_out == KEYS[k*WIDTH +: WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // count_q/ovf_q still hold the captured length during COMPARE.
    assign len_bad = (count_q != FULL_CNT) || ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            shift_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
            match     <= 1'b0;
            match_idx <= '0;
            len_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                COLLECT: begin
                    shift_q <= shift_nxt;
                    count_q <= count_nxt;
                    ovf_q   <= ovf_nxt;
                    if (end_of_sequence) begin
                        data_out <= shift_nxt;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    len_err   <= len_bad;
                    match     <= hit && !len_bad;
                    match_idx <= (hit && !len_bad) ? hit_idx : '0;
                    done      <= 1'b1;
                    shift_q   <= '0;
                    count_q   <= '0;
                    ovf_q     <= 1'b0;
                    state     <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_match.sv
module tb_stream_match;

    localparam int W = 128;
    localparam int NK = 4;
    localparam logic [W*NK-1:0] KEYS = {
        128'hFFEEDDCCBBAA99887766554433221100,
        128'h0123456789ABCDEFFEDCBA9876543210,
        128'hDEADBEEFCAFEF00D0BADC0DE12345678,
        128'h0
    };

    typedef struct {
        logic [W-1:0] data;
        logic         m;
        logic [1:0]   idx;
        logic         le;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bit_valid;
    logic         bit_in;
    logic         end_of_sequence;
    logic         bit_ready;
    logic [W-1:0] data_out;
    logic         done;
    logic         match;
    logic [1:0]   match_idx;
    logic         len_err;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int dones  = 0;
    exp_t sb[$];

    stream_match dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bit_valid       (bit_valid),
        .bit_in          (bit_in),
        .end_of_sequence (end_of_sequence),
        .bit_ready       (bit_ready),
        .data_out        (data_out),
        .done            (done),
        .match           (match),
        .match_idx       (match_idx),
        .len_err         (len_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] key(input int k);
        return KEYS[k*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic m, input logic [1:0] idx, input logic le);
        exp_t e;
        e.data = d;
        e.m    = m;
        e.idx  = idx;
        e.le   = le;
        sb.push_back(e);
        pushes++;
    endtask

    // Inputs change on the falling edge; the rising edge samples them.
    task automatic cycle(input logic v, input logic b, input logic e);
        bit_valid       = v;
        bit_in          = b;
        end_of_sequence = e;
        @(negedge clk);
        bit_valid       = 1'b0;
        bit_in          = 1'b0;
        end_of_sequence = 1'b0;
    endtask

    task automatic send_vec(input logic [W-1:0] vec, input int n, input logic eos_last);
        for (int i = n - 1; i >= 0; i--)
            cycle(1'b1, vec[i], (i == 0) ? eos_last : 1'b0);
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            dones++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_done observed=done expected=no_done");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_data", data_out, e.data);
                chk("sb_match", W'(match), W'(e.m));
                chk("sb_idx", W'(match_idx), W'(e.idx));
                chk("sb_len_err", W'(len_err), W'(e.le));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        end_of_sequence = 1'b0;
        #3;
        chk("rst_ready", W'(bit_ready), W'(1));
        chk("rst_data", data_out, '0);
        chk("rst_done", W'(done), W'(0));
        chk("rst_match", W'(match), W'(0));
        chk("rst_idx", W'(match_idx), W'(0));
        chk("rst_len_err", W'(len_err), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // key 1, end_of_sequence with the last bit
        push(key(1), 1'b1, 2'd1, 1'b0);
        send_vec(key(1), W, 1'b1);
        chk("k1_data_early", data_out, key(1));
        chk("k1_ready_compare", W'(bit_ready), W'(0));
        chk("k1_done_not_yet", W'(done), W'(0));
        cycle(1'b0, 1'b0, 1'b0);
        chk("k1_done", W'(done), W'(1));
        chk("k1_match", W'(match), W'(1));
        cycle(1'b0, 1'b0, 1'b0);
        chk("k1_done_one_cycle", W'(done), W'(0));
        chk("k1_ready_back", W'(bit_ready), W'(1));

        // 0xAA.. pattern, separate end_of_sequence, outputs then hold
        push({(W/2){2'b10}}, 1'b0, 2'd0, 1'b0);
        send_vec({(W/2){2'b10}}, W, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk("aa_hold_data", data_out, {(W/2){2'b10}});
        chk("aa_hold_len_err", W'(len_err), W'(0));

        // 64 ones, end_of_sequence held two cycles (second one lands in COMPARE)
        push({{(W/2){1'b0}}, {(W/2){1'b1}}}, 1'b0, 2'd0, 1'b1);
        send_vec({(W/2){1'b1}}, W/2, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // 129 bits: key 0 then one extra bit
        push(key(0), 1'b0, 2'd0, 1'b1);
        send_vec(key(0), W, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // empty sequence
        push('0, 1'b0, 2'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // exact-length all-zero sequence matches key 0
        push('0, 1'b1, 2'd0, 1'b0);
        send_vec('0, W, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // key 3
        push(key(3), 1'b1, 2'd3, 1'b0);
        send_vec(key(3), W, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // partial sequence killed by reset between edges, then key 2
        send_vec(32'hA5A5_5A5A, 40, 1'b0);
        #2;
        rst_n = 1'b0;
        #2;
        chk("rst_mid_data", data_out, '0);
        chk("rst_mid_match", W'(match), W'(0));
        chk("rst_mid_idx", W'(match_idx), W'(0));
        chk("rst_mid_ready", W'(bit_ready), W'(1));
        rst_n = 1'b1;
        @(negedge clk);
        push(key(2), 1'b1, 2'd2, 1'b0);
        send_vec(key(2), W, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // bit_valid held through COMPARE: that bit is dropped
        push(key(1), 1'b1, 2'd1, 1'b0);
        push(key(2), 1'b1, 2'd2, 1'b0);
        send_vec(key(1), W, 1'b1);
        chk("stream_ready_compare", W'(bit_ready), W'(0));
        cycle(1'b1, 1'b1, 1'b0);
        send_vec(key(2), W, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        chk("sb_empty", W'(sb.size()), W'(0));
        chk("done_count", W'(dones), W'(pushes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
